// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: turns an external simple dual-port block RAM with a
// registered, 1-cycle-latency read port into a first-word-fall-through FIFO.
// The head word lives on the RAM output register; the RAM holds the rest.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   FLUSH           synchronous clear of FIFO state (no write/read that cycle)
//   S_DATA/S_VALID/S_READY   producer handshake
//   M_DATA/M_VALID/M_READY   consumer handshake (M_DATA wired from RAM_DOUT)
//   RAM_COUNT       words in RAM with no read issued yet
//   ALMOST_FULL     RAM_COUNT >= ALMOST_FULL_TH
//   RAM_WR_PTR_EN/RAM_WR_EN/RAM_WR_PTR/RAM_DIN   RAM write port
//   RAM_RD_EN/RAM_RD_PTR/RAM_DOUT                RAM read port
module bram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH     = 72,
  parameter int unsigned PTR_WIDTH      = 3,
  parameter int unsigned ALMOST_FULL_TH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic [DATA_WIDTH-1:0] S_DATA,
  input  logic                  S_VALID,
  output logic                  S_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [PTR_WIDTH:0]    RAM_COUNT,
  output logic                  ALMOST_FULL,
  output logic                  RAM_WR_PTR_EN,
  output logic                  RAM_WR_EN,
  output logic [PTR_WIDTH-1:0]  RAM_WR_PTR,
  output logic [DATA_WIDTH-1:0] RAM_DIN,
  output logic                  RAM_RD_EN,
  output logic [PTR_WIDTH-1:0]  RAM_RD_PTR,
  input  logic [DATA_WIDTH-1:0] RAM_DOUT
);

  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
  localparam int unsigned DEPTH     = 2 ** PTR_WIDTH;

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 m_valid_q, m_valid_d;
  logic                 accept;
  logic                 issue;
  logic                 pop;

  // State registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
    end
  end

  // Handshake decode and next-state
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    m_valid_d = m_valid_q;

    S_READY = !RST && (count_q != CNT_WIDTH'(DEPTH));
    accept  = S_VALID && S_READY && !FLUSH;
    pop     = m_valid_q && M_READY;
    // A read only targets words whose write edge has already passed, so
    // the RAM never sees a same-address read/write in one cycle.
    issue   = !RST && !FLUSH && (count_q != '0) && (!m_valid_q || M_READY);

    if (FLUSH) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      m_valid_d = 1'b0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      if (issue)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      count_d = count_q + CNT_WIDTH'(accept) - CNT_WIDTH'(issue);
      // A fresh read refills the output register even as the old head pops.
      if (issue)    m_valid_d = 1'b1;
      else if (pop) m_valid_d = 1'b0;
    end
  end

  assign RAM_WR_PTR_EN = accept;
  assign RAM_WR_EN     = accept;
  assign RAM_WR_PTR    = wr_ptr_q;
  assign RAM_DIN       = S_DATA;
  assign RAM_RD_EN     = issue;
  assign RAM_RD_PTR    = rd_ptr_q;
  assign M_DATA        = RAM_DOUT;
  assign M_VALID       = m_valid_q;
  assign RAM_COUNT     = count_q;
  assign ALMOST_FULL   = (count_q >= CNT_WIDTH'(ALMOST_FULL_TH));

endmodule
